// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer that issues single-outstanding word reads and feeds decode from a 2-entry FIFO.
// Latency: an ack in cycle N is visible on insn/insn_valid in N+1, and the next mem_req also starts in N+1.
// Backpressure: decode_stall holds the FIFO head. With 2 words buffered, fetch parks in HOLD with mem_req low.
//
// Ports:
//   clock, reset               single rising-edge clock, synchronous active-high reset
//   mem_req/mem_addr           read request, held with a stable address until mem_ack
//   mem_ack/mem_rdata          one-cycle response strobe and returned instruction word
//   insn/insn_pc/insn_valid    FIFO head presented to decode
//   decode_stall               decode refuses the head this cycle
//   redirect/redirect_pc       one-cycle restart request and its target PC
//   fetch_error                misaligned redirect seen (sticky until reset)
//
// Build option FETCH_ALIGN_CHECK_EN: a misaligned redirect raises fetch_error and parks the
// sequencer in HALT until reset. Without it, redirect_pc[1:0] is ignored and fetch_error is 0.
module fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h8002_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [0:31] mem_rdata,
  output logic [0:31] insn,
  output logic [31:0] insn_pc,
  output logic        insn_valid,
  input  logic        decode_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_error
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DISCARD, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DISCARD} state_t;
`endif

  typedef struct packed {
    logic [0:31] insn;
    logic [31:0] pc;
  } fq_entry_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] discard_addr;   // address of the abandoned request while draining its ack
  logic [31:0] redir_tgt;
  logic        redir_take;

  fq_entry_t   fq_q [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  fq_cnt, fq_cnt_nxt;

  logic        push, pop;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        bad_align;
  assign bad_align  = |redirect_pc[1:0];
  assign redir_tgt  = redirect_pc;
  // HALT ignores further redirects.
  assign redir_take = redirect && (state != S_HALT);
`else
  assign redir_tgt  = redirect_pc & 32'hFFFF_FFFC;
  assign redir_take = redirect;
`endif

  assign insn_valid = (fq_cnt != 2'd0);
  assign insn       = fq_q[rd_ptr].insn;
  assign insn_pc    = fq_q[rd_ptr].pc;

  // Acks outside REQ are either dropped (DISCARD) or spurious.
  assign push = (state == S_REQ) && mem_ack;
  assign pop  = insn_valid && !decode_stall;

  always_comb begin
    fq_cnt_nxt = fq_cnt;
    if (redir_take) begin
      fq_cnt_nxt = 2'd0;
    end else if (push && !pop) begin
      fq_cnt_nxt = fq_cnt + 2'd1;
    end else if (pop && !push) begin
      fq_cnt_nxt = fq_cnt - 2'd1;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (redir_take) begin
          // An unacked request must be drained before the new PC can be issued.
          state_nxt = mem_ack ? S_REQ : S_DISCARD;
        end else if (mem_ack) begin
          state_nxt = (fq_cnt_nxt == 2'd2) ? S_HOLD : S_REQ;
        end
      end
      S_HOLD: begin
        if (redir_take || (fq_cnt_nxt != 2'd2)) begin
          state_nxt = S_REQ;
        end
      end
      S_DISCARD: begin
        if (mem_ack) begin
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase
`ifdef FETCH_ALIGN_CHECK_EN
    if (redir_take && bad_align) begin
      state_nxt = S_HALT;
    end
`endif
  end

  // Output logic. mem_req is masked by reset so it reads 0 for every cycle reset is held.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = pc;
    case (state)
      S_REQ: begin
        mem_req = !reset;
      end
      S_DISCARD: begin
        mem_req  = !reset;
        mem_addr = discard_addr;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // PC and FIFO datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      pc           <= PC_RESET;
      discard_addr <= PC_RESET;
      fq_cnt       <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      fq_q[0]      <= '0;
      fq_q[1]      <= '0;
    end else begin
      fq_cnt <= fq_cnt_nxt;
      if (redir_take) begin
        // A flush overrides any push or pop in the same cycle.
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        pc     <= redir_tgt;
        if ((state == S_REQ) && !mem_ack) begin
          discard_addr <= pc;
        end
      end else begin
        if (push) begin
          fq_q[wr_ptr] <= '{insn: mem_rdata, pc: pc};
          wr_ptr       <= !wr_ptr;
          pc           <= pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= !rd_ptr;
        end
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_error <= 1'b0;
    end else if (redir_take && bad_align) begin
      fetch_error <= 1'b1;
    end
  end
`else
  assign fetch_error = 1'b0;
`endif

endmodule
